// File: rtl/mem_ctrl.sv
// KS10 main-memory controller: takes one arbiter bus cycle at a time, sequences
// a synchronous single-port SRAM and returns a one-clock acknowledge.
module mem_ctrl #(
    parameter int unsigned MEMSIZE = 262144,
    parameter int unsigned RD_LAT  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        busREQI,
    input  logic [0:35] busADDRI,
    input  logic [0:35] busDATAI,
    output logic        busACKO,
    output logic [0:35] busDATAO,
    output logic [19:0] ssramADDR,
    output logic [0:35] ssramDATO,
    input  logic [0:35] ssramDATI,
    output logic        ssramRD,
    output logic        ssramWR
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [2:0] LAT = 3'(RD_LAT);

    state_t      state, state_nxt;
    logic [2:0]  cnt, cnt_nxt;
    logic        wr_ack_pend, wr_ack_pend_nxt;
    logic        ack_nxt;
    logic [0:35] bus_data_nxt;
    logic [19:0] sram_addr_nxt;
    logic [0:35] sram_data_nxt;
    logic        sram_rd_nxt, sram_wr_nxt;
    logic        latch_en;

    logic [19:0] addr_lat;
    logic [0:35] data_lat;
    logic        rmw_lat;

    logic        cyc_read, cyc_write, cyc_io, cyc_in_range, cyc_ok;
    logic [19:0] cyc_addr;
    logic        unused_bits;

    assign cyc_read     = busADDRI[3];
    assign cyc_write    = busADDRI[5];
    assign cyc_io       = busADDRI[6];
    assign cyc_addr     = busADDRI[16:35];
    assign cyc_in_range = 32'(cyc_addr) < MEMSIZE;
    assign cyc_ok       = busREQI && !cyc_io && (cyc_read || cyc_write) && cyc_in_range;
    assign unused_bits  = ^{busADDRI[0:2], busADDRI[4], busADDRI[7:15]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        wr_ack_pend_nxt = 1'b0;
        ack_nxt         = wr_ack_pend;
        bus_data_nxt    = '0;
        sram_addr_nxt   = ssramADDR;
        sram_data_nxt   = ssramDATO;
        sram_rd_nxt     = 1'b0;
        sram_wr_nxt     = 1'b0;
        latch_en        = 1'b0;
        unique case (state)
            IDLE: begin
                if (cyc_ok) begin
                    latch_en      = 1'b1;
                    sram_addr_nxt = cyc_addr;
                    if (cyc_write && !cyc_read) begin
                        state_nxt = WR;
                    end else begin
                        state_nxt   = RD;
                        sram_rd_nxt = 1'b1;
                        cnt_nxt     = '0;
                    end
                end else if (busREQI) begin
                    // NXM / IO / flagless cycles are swallowed; the initiator times out
                    state_nxt = DONE;
                end
            end
            RD: begin
                if (cnt == LAT) begin
                    ack_nxt      = 1'b1;
                    bus_data_nxt = ssramDATI;
                    state_nxt    = rmw_lat ? WR : DONE;
                end else begin
                    cnt_nxt = cnt + 3'd1;
                end
            end
            WR: begin
                sram_wr_nxt     = 1'b1;
                sram_addr_nxt   = addr_lat;
                sram_data_nxt   = data_lat;
                // the RMW already acknowledged with the old data
                wr_ack_pend_nxt = !rmw_lat;
                state_nxt       = DONE;
            end
            DONE: begin
                if (!busREQI) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            wr_ack_pend <= 1'b0;
            busACKO     <= 1'b0;
            busDATAO    <= '0;
            ssramADDR   <= '0;
            ssramDATO   <= '0;
            ssramRD     <= 1'b0;
            ssramWR     <= 1'b0;
        end else begin
            cnt         <= cnt_nxt;
            wr_ack_pend <= wr_ack_pend_nxt;
            busACKO     <= ack_nxt;
            busDATAO    <= bus_data_nxt;
            ssramADDR   <= sram_addr_nxt;
            ssramDATO   <= sram_data_nxt;
            ssramRD     <= sram_rd_nxt;
            ssramWR     <= sram_wr_nxt;
        end
    end

    // cycle capture: bus changes after acceptance are ignored
    always_ff @(posedge clk) begin
        if (latch_en) begin
            addr_lat <= cyc_addr;
            data_lat <= busDATAI;
            rmw_lat  <= cyc_read && cyc_write;
        end
    end

endmodule
